mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and signed divide (restoring on magnitudes)
// for the HI/LO register path; one iteration per cycle, 32 iterations per operation.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [1:0]  dbg_state_o
);

  // Handshake: start_mult/start_div are single-cycle requests sampled when the
  // unit can accept (IDLE, or the FINISH cycle that returns to IDLE); there is no
  // ready signal and no queuing, so a request arriving while busy is dropped.
  // done and div_zero are one-cycle registered pulses with no back-pressure.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t      state_q;
  logic [5:0]  count_q;
  logic [32:0] acc_q;      // Booth upper half, or partial remainder
  logic [31:0] q_q;        // Booth multiplier / low product, or quotient
  logic [31:0] m_q;        // multiplicand, or divisor magnitude
  logic        q1_q;       // Booth q(-1) bit
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;
  logic        dz_q;

  logic [32:0] m_ext;
  logic [32:0] booth_sum;
  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic [32:0] rem_n;
  logic [31:0] quo_n;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        last_iter;
  logic        can_start;

  always_comb begin
    m_ext = {m_q[31], m_q};
    case ({q_q[0], q1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase

    // Remainder never exceeds 2^32-1 after the shift, so bit 32 of the
    // trial subtraction is a reliable borrow flag.
    rem_sh = {acc_q[31:0], q_q[31]};
    trial  = rem_sh - {1'b0, m_q};
    if (!trial[32]) begin
      rem_n = trial;
      quo_n = {q_q[30:0], 1'b1};
    end else begin
      rem_n = rem_sh;
      quo_n = {q_q[30:0], 1'b0};
    end
    quo_fix = neg_quo_q ? (32'd0 - quo_n) : quo_n;
    rem_fix = neg_rem_q ? (32'd0 - rem_n[31:0]) : rem_n[31:0];

    a_mag     = a[31] ? (32'd0 - a) : a;
    b_mag     = b[31] ? (32'd0 - b) : b;
    last_iter = (count_q == 6'd31);
    can_start = (state_q == IDLE) || ((state_q == FINISH) && done_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= 6'd0;
      acc_q     <= 33'd0;
      q_q       <= 32'd0;
      m_q       <= 32'd0;
      q1_q      <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;

      case (state_q)
        IDLE: begin
        end
        MULT: begin
          acc_q <= {booth_sum[32], booth_sum[32:1]};
          q_q   <= {booth_sum[0], q_q[31:1]};
          q1_q  <= q_q[0];
          if (last_iter) state_q <= FINISH;
          else           count_q <= count_q + 6'd1;
        end
        DIV: begin
          if (last_iter) begin
            acc_q   <= {1'b0, rem_fix};
            q_q     <= quo_fix;
            state_q <= FINISH;
          end else begin
            acc_q   <= rem_n;
            q_q     <= quo_n;
            count_q <= count_q + 6'd1;
          end
        end
        FINISH: begin
          // First FINISH cycle publishes the result; the second returns to IDLE.
          if (!done_q) begin
            hi_q   <= acc_q[31:0];
            lo_q   <= q_q;
            done_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (can_start && start_mult) begin
        state_q <= MULT;
        busy_q  <= 1'b1;
        count_q <= 6'd0;
        acc_q   <= 33'd0;
        q_q     <= b;
        m_q     <= a;
        q1_q    <= 1'b0;
      end else if (can_start && start_div) begin
        if (b == 32'd0) begin
          dz_q    <= 1'b1;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else begin
          state_q   <= DIV;
          busy_q    <= 1'b1;
          count_q   <= 6'd0;
          acc_q     <= 33'd0;
          q_q       <= a_mag;
          m_q       <= b_mag;
          q1_q      <= 1'b0;
          neg_quo_q <= a[31] ^ b[31];
          neg_rem_q <= a[31];
        end
      end
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_zero    = dz_q;
  assign dbg_state_o = state_q;

endmodule
